cv32e40p_prefetch_queue: RTL and testbench

Instruction prefetch queue between the OBI instruction interface and the IF-stage fetch control FSM. It issues word-aligned fetch transactions and tracks outstanding responses. Returned words are buffered in a small in-order FIFO and presented to the IF stage through the `fetch_valid_o` / `fetch_ready_i` handshake. On `branch_req_i` the queue flushes all buffered and in-flight data, then restarts fetching at the branch target.

---
 rtl/cv32e40p_prefetch_queue_pkg.sv | 16 +
 rtl/cv32e40p_prefetch_queue_if.sv | 34 +++
 rtl/cv32e40p_prefetch_fifo.sv | 51 +++++
 rtl/cv32e40p_prefetch_queue.sv | 82 ++++++++
 tb/tb_cv32e40p_prefetch_queue.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_prefetch_queue_pkg.sv
// cv32e40p_prefetch_queue_pkg: prefetch queue defaults, FIFO entry type and address helper.
package cv32e40p_prefetch_queue_pkg;

    localparam int PREFETCH_DEPTH           = 2;
    localparam int PREFETCH_MAX_OUTSTANDING = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/cv32e40p_prefetch_queue_if.sv
// cv32e40p_prefetch_queue_if: IF-stage handshake and OBI instruction bus signals of the prefetch queue.
interface cv32e40p_prefetch_queue_if;

    logic        req_i;
    logic        branch_req_i;
    logic [31:0] branch_addr_i;
    logic        fetch_ready_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_err_o;
    logic        trans_valid_o;
    logic        trans_ready_i;
    logic [31:0] trans_addr_o;
    logic        resp_valid_i;
    logic [31:0] resp_rdata_i;
    logic        resp_err_i;
    logic        busy_o;

    modport slave (
        input  req_i, branch_req_i, branch_addr_i, fetch_ready_i,
        input  trans_ready_i, resp_valid_i, resp_rdata_i, resp_err_i,
        output fetch_valid_o, fetch_rdata_o, fetch_addr_o, fetch_err_o,
        output trans_valid_o, trans_addr_o, busy_o
    );

    modport master (
        output req_i, branch_req_i, branch_addr_i, fetch_ready_i,
        output trans_ready_i, resp_valid_i, resp_rdata_i, resp_err_i,
        input  fetch_valid_o, fetch_rdata_o, fetch_addr_o, fetch_err_o,
        input  trans_valid_o, trans_addr_o, busy_o
    );

endinterface

// File: rtl/cv32e40p_prefetch_fifo.sv
// cv32e40p_prefetch_fifo: in-order FIFO of fetched words with error flag and synchronous flush.
module cv32e40p_prefetch_fifo
    import cv32e40p_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = PREFETCH_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fetch_entry_t             wdata_i,
    input  logic                     pop_i,
    output fetch_entry_t             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_mem  <= '{default: '0};
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push_i) begin
                r_mem[r_wptr[AW-1:0]] <= wdata_i;
                r_wptr                <= r_wptr + (AW+1)'(1);
            end
            if (pop_i)
                r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    assign count_o = r_wptr - r_rptr;
    assign empty_o = count_o == '0;
    assign full_o  = count_o == (AW+1)'(DEPTH);
    assign rdata_o = r_mem[r_rptr[AW-1:0]];

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push_i && full_o));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));

endmodule

// File: rtl/cv32e40p_prefetch_queue.sv
// cv32e40p_prefetch_queue: credit-based instruction prefetcher between OBI and the IF stage,
// flushing buffered and in-flight words on a branch.
module cv32e40p_prefetch_queue
    import cv32e40p_prefetch_queue_pkg::*;
#(
    parameter int DEPTH           = PREFETCH_DEPTH,
    parameter int MAX_OUTSTANDING = PREFETCH_MAX_OUTSTANDING
) (
    input logic                        clk,
    input logic                        rst,
    cv32e40p_prefetch_queue_if.slave   bus
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(DEPTH) + 1;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_flush_cnt;
    logic [31:0]   r_next_addr;
    logic [31:0]   r_fetch_addr;
    logic [FW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_trans_valid;
    logic          w_fetch_valid;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    fetch_entry_t  w_head;

    // Outstanding transactions reserve FIFO slots, so a response always has room.
    assign w_trans_valid = bus.req_i & ~bus.branch_req_i
                         & (32'(r_cnt) < MAX_OUTSTANDING)
                         & (32'(r_cnt) + 32'(w_count) < DEPTH);
    assign w_accept      = w_trans_valid & bus.trans_ready_i;
    assign w_push        = bus.resp_valid_i & ~bus.branch_req_i & (r_flush_cnt == '0);
    assign w_fetch_valid = ~w_empty & ~bus.branch_req_i;
    assign w_pop         = w_fetch_valid & bus.fetch_ready_i;

    cv32e40p_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.branch_req_i),
        .push_i  (w_push),
        .wdata_i ({bus.resp_rdata_i, bus.resp_err_i}),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .count_o (w_count),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_flush_cnt  <= '0;
            r_next_addr  <= '0;
            r_fetch_addr <= '0;
        end else begin
            r_cnt        <= (w_accept & ~bus.resp_valid_i) ? r_cnt + CW'(1) :
                            (~w_accept & bus.resp_valid_i) ? r_cnt - CW'(1) : r_cnt;
            // A response landing in the branch cycle is dropped here, so it is not counted.
            r_flush_cnt  <= bus.branch_req_i ? r_cnt - CW'(bus.resp_valid_i) :
                            (bus.resp_valid_i && r_flush_cnt != '0) ? r_flush_cnt - CW'(1) : r_flush_cnt;
            r_next_addr  <= bus.branch_req_i ? word_align(bus.branch_addr_i) :
                            w_accept ? r_next_addr + 32'd4 : r_next_addr;
            r_fetch_addr <= bus.branch_req_i ? word_align(bus.branch_addr_i) :
                            w_pop ? r_fetch_addr + 32'd4 : r_fetch_addr;
        end
    end

    assign bus.trans_valid_o = w_trans_valid;
    assign bus.trans_addr_o  = r_next_addr;
    assign bus.fetch_valid_o = w_fetch_valid;
    assign bus.fetch_rdata_o = w_head.rdata;
    assign bus.fetch_err_o   = w_head.err;
    assign bus.fetch_addr_o  = r_fetch_addr;
    assign bus.busy_o        = (r_cnt != '0) | ~w_empty;

    a_resp_expected: assert property (@(posedge clk) disable iff (rst) !(bus.resp_valid_i && r_cnt == '0));

endmodule

// File: tb/tb_cv32e40p_prefetch_queue.sv
// tb_cv32e40p_prefetch_queue: directed test-plan scenarios plus random traffic,
// checked cycle by cycle against a transaction-level queue model.
module tb_cv32e40p_prefetch_queue;

    localparam int DEPTH = 2;
    localparam int MAXO  = 2;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } txn_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    txn_t        pend[$];
    ent_t        fifo[$];
    logic [31:0] next_addr = 32'h0;

    cv32e40p_prefetch_queue_if bus();

    cv32e40p_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // One clock cycle: drive, compare against the model, advance the model, then clock.
    task automatic step(input logic req, input logic br, input logic [31:0] ba, input logic fr,
                        input logic tr, input logic rv, input logic [31:0] rd, input logic re);
        logic exp_tv, exp_fv, rv_eff;
        txn_t t;
        rv_eff = rv && pend.size() != 0;
        bus.req_i         = req;
        bus.branch_req_i  = br;
        bus.branch_addr_i = ba;
        bus.fetch_ready_i = fr;
        bus.trans_ready_i = tr;
        bus.resp_valid_i  = rv_eff;
        bus.resp_rdata_i  = rd;
        bus.resp_err_i    = re;
        #1;
        exp_tv = req && !br && pend.size() < MAXO && pend.size() + fifo.size() < DEPTH;
        exp_fv = fifo.size() != 0 && !br;
        check("trans_valid", 32'(bus.trans_valid_o), 32'(exp_tv));
        check("trans_addr", bus.trans_addr_o, next_addr);
        check("fetch_valid", 32'(bus.fetch_valid_o), 32'(exp_fv));
        check("busy", 32'(bus.busy_o), 32'(pend.size() != 0 || fifo.size() != 0));
        if (exp_fv) begin
            check("fetch_rdata", bus.fetch_rdata_o, fifo[0].data);
            check("fetch_addr", bus.fetch_addr_o, fifo[0].addr);
            check("fetch_err", 32'(bus.fetch_err_o), 32'(fifo[0].err));
        end
        if (exp_fv && fr) void'(fifo.pop_front());
        if (rv_eff) begin
            t = pend.pop_front();
            if (!br && !t.stale) fifo.push_back('{t.addr, rd, re});
        end
        if (br) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            fifo.delete();
            next_addr = {ba[31:2], 2'b00};
        end
        if (exp_tv && tr) begin
            pend.push_back('{next_addr, 1'b0});
            next_addr = next_addr + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic req, input logic fr, input logic tr, input logic rv, input int n);
        for (int i = 0; i < n; i++) step(req, 1'b0, 32'h0, fr, tr, rv, $urandom, 1'b0);
    endtask

    task automatic branch(input logic [31:0] ba);
        step(1'b1, 1'b1, ba, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        bus.req_i = 0; bus.branch_req_i = 0; bus.branch_addr_i = 0; bus.fetch_ready_i = 0;
        bus.trans_ready_i = 0; bus.resp_valid_i = 0; bus.resp_rdata_i = 0; bus.resp_err_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_trans_addr", bus.trans_addr_o, 32'h0);
        check("rst_fetch_addr", bus.fetch_addr_o, 32'h0);
        check("rst_fetch_valid", 32'(bus.fetch_valid_o), 32'h0);
        check("rst_trans_valid", 32'(bus.trans_valid_o), 32'h0);
        check("rst_busy", 32'(bus.busy_o), 32'h0);
        check("rst_fetch_rdata", bus.fetch_rdata_o, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // basic fetch: 0x80 -> 0xA, 0x84 -> 0xB
        branch(32'h80);
        step(1, 0, 0, 1, 1, 0, 32'h0, 0);
        step(1, 0, 0, 1, 1, 1, 32'hA, 0);
        step(1, 0, 0, 1, 1, 1, 32'hB, 0);
        go(0, 1, 1, 0, 3);
        check("basic_idle_busy", 32'(bus.busy_o), 32'h0);
        // backpressure: two issued, then stall until a pop
        branch(32'h80);
        go(1, 0, 1, 1, 6);
        go(1, 1, 1, 1, 6);
        go(0, 1, 1, 1, 4);
        // flush with two transactions in flight
        branch(32'h80);
        go(1, 1, 1, 0, 3);
        branch(32'h200);
        go(0, 1, 1, 1, 2);
        go(1, 1, 1, 1, 6);
        go(0, 1, 1, 1, 4);
        // branch coincident with the only outstanding response
        branch(32'h80);
        step(1, 0, 0, 1, 1, 0, 32'h0, 0);
        step(0, 1, 32'h300, 1, 1, 1, 32'h1234, 0);
        check("coincident_busy", 32'(bus.busy_o), 32'h0);
        go(1, 1, 1, 1, 4);
        go(0, 1, 1, 1, 4);
        // error response at 0x100
        branch(32'h100);
        step(1, 0, 0, 0, 1, 0, 32'h0, 0);
        step(1, 0, 0, 0, 1, 1, 32'hE0, 1);
        step(0, 0, 0, 0, 1, 1, 32'hE4, 0);
        check("err_head", 32'(bus.fetch_err_o), 32'h1);
        go(0, 1, 1, 1, 3);
        // wrap-around of both address registers
        branch(32'hFFFF_FFFE);
        check("wrap_trans_addr", bus.trans_addr_o, 32'hFFFF_FFFC);
        go(1, 1, 1, 1, 8);
        go(0, 1, 1, 1, 4);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            logic        br;
            logic [31:0] ba;
            br = ($urandom_range(0, 99) < 6);
            ba = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            step($urandom_range(0, 9) != 0, br, ba, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom,
                 $urandom_range(0, 7) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
